// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the MEM stage.
// WBsel and funct3 encodings, MEM FSM states, alignment helper.
package riscv_pkg;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t REQ  = 1'b1;

  // size field is funct3[1:0]; unsigned variants share it
  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    return (sz == 2'b01 && off[0]) ||
           (sz == 2'b10 && off != 2'b00);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter: lane-shift and extend load data.
// in: rdata, offset, funct3; out: data.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = rdata >> {offset, 3'b000};

  always_comb begin
    data = sh;
    unique case (1'b1)
      (funct3 == F3_B):  data = {{24{sh[7]}}, sh[7:0]};
      (funct3 == F3_H):  data = {{16{sh[15]}}, sh[15:0]};
      (funct3 == F3_W):  data = sh;
      (funct3 == F3_BU): data = {24'h0, sh[7:0]};
      (funct3 == F3_HU): data = {16'h0, sh[15:0]};
      default:           data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage, req/ack dmem port, MEM/WB regs.
// in: EX/MEM bundle, dmem_ack/rdata; out: dmem_*, stall, MEM/WB.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] regOut_B_in,
  input  logic        RegWEn_in,
  input  logic        MemRW_in,
  input  logic [1:0]  WBsel_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] load_data_out,
  output logic        RegWEn_out,
  output logic [1:0]  WBsel_out
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] h_pc;
  logic [31:0] h_ins;
  logic [31:0] h_addr;
  logic        h_rwe;
  logic [1:0]  h_wbs;
  logic        h_st;

  logic [2:0]  f3;
  logic [1:0]  off;
  logic        mem_op;
  logic        mis;
  logic        tmo;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] fmt;

  assign f3     = instruction_in[14:12];
  assign off    = ALU_result_in[1:0];
  assign mem_op = MemRW_in | (WBsel_in == WB_MEM);
  assign mis    = misaligned(f3[1:0], off);
  assign tmo    = (state == REQ) && !dmem_ack &&
                  (cnt == LAST);

  // the timeout cycle releases the pipe; the op is dropped
  always_comb begin
    stall_o = 1'b0;
    if (state == IDLE)
      stall_o = mem_op && !mis;
    else
      stall_o = !dmem_ack && !tmo;
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = regOut_B_in;
    unique case (1'b1)
      (f3[1:0] == 2'b00): begin
        be_n = 4'b0001 << off;
        wd_n = {4{regOut_B_in[7:0]}};
      end
      (f3[1:0] == 2'b01): begin
        be_n = off[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{regOut_B_in[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = regOut_B_in;
      end
    endcase
  end

  load_formatter u_fmt (
    .rdata  (dmem_rdata),
    .offset (h_addr[1:0]),
    .funct3 (h_ins[14:12]),
    .data   (fmt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      h_pc            <= 32'd0;
      h_ins           <= 32'd0;
      h_addr          <= 32'd0;
      h_rwe           <= 1'b0;
      h_wbs           <= 2'b00;
      h_st            <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'd0;
      dmem_wdata      <= 32'd0;
      dmem_be         <= 4'd0;
      misaligned_o    <= 1'b0;
      bus_err_o       <= 1'b0;
      pc_out          <= 32'd0;
      instruction_out <= 32'd0;
      ALU_result_out  <= 32'd0;
      load_data_out   <= 32'd0;
      RegWEn_out      <= 1'b0;
      WBsel_out       <= 2'b00;
    end else begin
      // MEM/WB holds a bubble unless a result retires
      misaligned_o    <= 1'b0;
      bus_err_o       <= 1'b0;
      pc_out          <= 32'd0;
      instruction_out <= 32'd0;
      ALU_result_out  <= 32'd0;
      load_data_out   <= 32'd0;
      RegWEn_out      <= 1'b0;
      WBsel_out       <= 2'b00;
      unique case (state)
        IDLE: begin
          if (!mem_op) begin
            pc_out          <= pc_in;
            instruction_out <= instruction_in;
            ALU_result_out  <= ALU_result_in;
            RegWEn_out      <= RegWEn_in;
            WBsel_out       <= WBsel_in;
          end else if (mis) begin
            misaligned_o <= 1'b1;
          end else begin
            h_pc       <= pc_in;
            h_ins      <= instruction_in;
            h_addr     <= ALU_result_in;
            h_rwe      <= RegWEn_in;
            h_wbs      <= WBsel_in;
            h_st       <= MemRW_in;
            dmem_req   <= 1'b1;
            dmem_we    <= MemRW_in;
            dmem_addr  <= {ALU_result_in[31:2], 2'b00};
            dmem_wdata <= MemRW_in ? wd_n : 32'd0;
            dmem_be    <= MemRW_in ? be_n : 4'd0;
            cnt        <= 8'd0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req        <= 1'b0;
            pc_out          <= h_pc;
            instruction_out <= h_ins;
            ALU_result_out  <= h_addr;
            RegWEn_out      <= h_rwe;
            WBsel_out       <= h_wbs;
            load_data_out   <= h_st ? 32'd0 : fmt;
            state           <= IDLE;
          end else if (tmo) begin
            dmem_req  <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline. Sits directly downstream of the EX/MEM register and consumes its outputs.
- Performs load/store accesses on a variable-latency data-memory port using a req/ack handshake, and stalls the pipe while an access is outstanding.
- Formats load data (byte/half/word, signed/unsigned) and registers results into the MEM/WB boundary.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for dmem_ack before aborting with bus error; range 1..255.

Ports:
- clk in 1: clock, rising edge
- reset_n in 1: asynchronous, active-low reset
- pc_in in 32: from EX/MEM
- instruction_in in 32: from EX/MEM; funct3 = [14:12]
- ALU_result_in in 32: effective address / ALU value
- regOut_B_in in 32: store data
- RegWEn_in in 1
- MemRW_in in 1: 1 = store
- WBsel_in in 2: 00 mem, 01 ALU, 10 PC+4
- dmem_req out 1: registered request
- dmem_we out 1: registered, 1 = write
- dmem_addr out 32: registered, word-aligned ({addr[31:2],2'b00})
- dmem_wdata out 32: registered, lane-shifted store data
- dmem_be out 4: registered byte enables
- dmem_ack in 1: one-cycle completion pulse
- dmem_rdata in 32: valid when dmem_ack=1
- stall_o out 1: combinational; hold EX/MEM and earlier stages
- misaligned_o out 1: registered one-cycle pulse
- bus_err_o out 1: registered one-cycle pulse
- pc_out, instruction_out, ALU_result_out, load_data_out out 32 each: MEM/WB registers
- RegWEn_out out 1, WBsel_out out 2: MEM/WB registers

Behaviour:
- Reset (async, reset_n=0): all outputs 0 (bubble); state IDLE; timeout counter 0; any outstanding dmem_req dropped immediately.
- mem_op = MemRW_in | (WBsel_in==00).
  - load = WBsel_in==00 and not MemRW_in.
  - store = MemRW_in.
- Misalignment, checked in IDLE:
  - half (funct3[1:0]=01) with addr[0]=1.
  - word (10) with addr[1:0]!=0.
- State IDLE:
  - Non-mem op: MEM/WB registers load the inputs next edge; load_data_out=0. Latency 1, no stall.
  - Misaligned mem op: no bus access; misaligned_o=1 next cycle; MEM/WB loads a bubble (all 0); no stall.
  - Aligned mem op: stall_o=1. Next edge: capture pc/instr/addr/funct3/RegWEn/WBsel into hold registers, drive dmem_* for one request, go to REQ, clear counter. MEM/WB loads a bubble.
- State REQ:
  - dmem_req held at 1; dmem_addr/we/wdata/be held stable.
  - stall_o = !dmem_ack.
  - dmem_ack=1: deassert req next edge; MEM/WB loads the held fields plus formatted load data (stores: load_data_out=0); go to IDLE. The EX/MEM contents advance on the same edge.
  - No ack: counter increments. When counter = TIMEOUT_CYCLES-1 with no ack, the next edge drops req, pulses bus_err_o, loads a bubble (RegWEn_out=0), goes to IDLE, and stall_o is 0 in that cycle.
  - Ack and timeout in the same cycle: ack wins.
- Minimum mem-op occupancy: 2 cycles (issue plus ack cycle).
- dmem_ack while in IDLE: ignored.
- Store lanes, byte offset o = addr[1:0]:
  - sb: be = 1<<o; wdata = {4{B[7:0]}}.
  - sh: be = 0011 or 1100; wdata = {2{B[15:0]}}.
  - sw: be = 1111; wdata = B.
  - Loads: be = 0000, we = 0.
- Load format: rdata shifted right by 8*o.
  - funct3 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: full word.
  - 100 lbu / 101 lhu: zero-extend.
  - Other funct3: word, no extension.
- Counter width: 8 bits; never wraps (bounded by timeout).

Decomposition:
- Shared package (riscv_pkg):
  - WBsel encodings WB_MEM/WB_ALU/WB_PC4.
  - funct3 constants F3_B/H/W/BU/HU.
  - FSM state enum {IDLE, REQ}.
- Sub-module load_formatter: combinational; inputs rdata, offset, funct3; output 32-bit formatted data. Reused by the verification model.

Test Plan:
1. Reset mid-REQ: reset_n=0 while dmem_req=1 → dmem_req=0 and all outputs 0 within the same cycle; after release, state IDLE, stall_o=0.
2. ALU op, WBsel=01, ALU_result=0x1234 → next cycle ALU_result_out=0x1234, RegWEn_out=1, stall_o never asserted.
3. lb at addr 0x103, ack after 3 wait cycles with rdata=0x80FF_0000:
   - stall_o high for 4 cycles; dmem_addr=0x100, be=0000.
   - load_data_out=0xFFFF_FF80 on the cycle after ack.
4. sh at 0x202, B=0xABCD_1234 → dmem_we=1, be=1100, wdata=0x1234_1234; with zero-wait ack, one-cycle stall.
5. lw at 0x301 → no dmem_req; misaligned_o pulses once; RegWEn_out=0.
6. TIMEOUT_CYCLES=4, lw with no ack → bus_err_o pulses after 4 REQ cycles, req dropped, bubble output, stall released. Repeat with ack on the 4th cycle → normal completion, no error.
